fetch: RTL and testbench

Instruction-fetch stage of the five-stage rv32i pipeline, sitting directly upstream of decode. Owns the program counter, issues one read at a time to the instruction cache, and registers each returned instruction with its PC into the fetch/decode pipeline register. Honors the pipeline stall and takes PC redirects from branch/jump resolution, squashing wrong-path fetches. A cache read cannot be cancelled once it is outstanding.

---
 rtl/fetch_if.sv | 24 ++
 rtl/fetch.sv | 120 ++++++++++++
 tb/tb_fetch.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage, the instruction cache and the
// decode/branch-resolution side of the pipeline.
interface fetch_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    modport master (
        output imem_read, imem_address, pc_out, instruction_out, valid_out,
        input  imem_resp, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_read, imem_address, pc_out, instruction_out, valid_out,
        output imem_resp, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch.sv
// rv32i instruction-fetch stage: owns the PC, keeps one cache read in flight
// and fills the fetch/decode register, honoring stall and redirect.
//   state   | meaning
//   FETCH   | request at pc outstanding, response accepted or skid-buffered
//   HOLD    | response parked in buf_q while decode is stalled, no request
//   DISCARD | wrong-path request still in flight, its response is dropped
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  fetch_io
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            target_q <= '0;
            buf_q    <= '0;
            pc_out_q <= '0;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            buf_q    <= buf_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        buf_d    = buf_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        case (state_q)
            FETCH: begin
                if (fetch_io.imem_resp) begin
                    if (fetch_io.redirect) begin
                        pc_d    = fetch_io.redirect_pc;
                        valid_d = 1'b0;
                    end else if (!fetch_io.stall) begin
                        pc_out_d = pc_q;
                        instr_d  = fetch_io.imem_rdata;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end else begin
                        buf_d   = fetch_io.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (fetch_io.redirect) begin
                    // the read cannot be cancelled; remember where to go once it returns
                    target_d = fetch_io.redirect_pc;
                    valid_d  = 1'b0;
                    state_d  = DISCARD;
                end else if (!fetch_io.stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (fetch_io.redirect) begin
                    pc_d    = fetch_io.redirect_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!fetch_io.stall) begin
                    pc_out_d = pc_q;
                    instr_d  = buf_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                valid_d = 1'b0;
                if (fetch_io.redirect) begin
                    target_d = fetch_io.redirect_pc;
                end
                if (fetch_io.imem_resp) begin
                    pc_d    = fetch_io.redirect ? fetch_io.redirect_pc : target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        fetch_io.imem_read       = !reset && (state_q != HOLD);
        fetch_io.imem_address    = pc_q;
        fetch_io.pc_out          = pc_out_q;
        fetch_io.instruction_out = instr_q;
        fetch_io.valid_out       = valid_q;
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: scripted cache/pipeline stimulus,
// with accepted instructions tracked in an expected-output queue.
module tb_fetch;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_if f ();

    fetch dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_io (f)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0020_0113;
    localparam logic [31:0] W2  = 32'h0030_0193;
    localparam logic [31:0] W3  = 32'h0040_0213;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic [31:0] last_pc    = '0;
    logic [31:0] last_ins   = '0;
    logic        prev_stall = 1'b0;

    always @(posedge clk) prev_stall <= f.stall;

    // Output scoreboard: a valid output after an unstalled edge is a new
    // instruction; after a stalled edge it must be the previous one, held.
    always @(negedge clk) begin
        if (!reset && f.valid_out === 1'b1) begin
            checks++;
            if (!prev_stall) begin
                if (exp_pc_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: pc_out=%h instruction_out=%h, required no instruction",
                             f.pc_out, f.instruction_out);
                end else begin
                    last_pc  = exp_pc_q.pop_front();
                    last_ins = exp_ins_q.pop_front();
                    if (f.pc_out !== last_pc || f.instruction_out !== last_ins) begin
                        failures++;
                        $display("FAIL sb_new: pc_out=%h instruction_out=%h, required %h %h",
                                 f.pc_out, f.instruction_out, last_pc, last_ins);
                    end
                end
            end else if (f.pc_out !== last_pc || f.instruction_out !== last_ins) begin
                failures++;
                $display("FAIL sb_hold: pc_out=%h instruction_out=%h, required %h %h",
                         f.pc_out, f.instruction_out, last_pc, last_ins);
            end
        end
    end

    task automatic drive(input logic resp, input logic [31:0] rdata, input logic st,
                         input logic rd, input logic [31:0] rpc);
        f.imem_resp   = resp;
        f.imem_rdata  = rdata;
        f.stall       = st;
        f.redirect    = rd;
        f.redirect_pc = rpc;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        exp_pc_q.push_back(pc);
        exp_ins_q.push_back(ins);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b0) begin
            failures++;
            $display("FAIL reset_read: got %b, required 0", f.imem_read);
        end
        checks++;
        if (f.valid_out !== 1'b0 || f.pc_out !== 32'h0 || f.instruction_out !== 32'h13) begin
            failures++;
            $display("FAIL reset_out: valid=%b pc=%h ins=%h, required 0 00000000 00000013",
                     f.valid_out, f.pc_out, f.instruction_out);
        end
        checks++;
        if (f.imem_address !== 32'h60) begin
            failures++;
            $display("FAIL reset_pc: got %h, required 00000060", f.imem_address);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h60) begin
            failures++;
            $display("FAIL reset_first_req: read=%b addr=%h, required 1 00000060",
                     f.imem_read, f.imem_address);
        end
        next_cycle();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h13, 1'b0, 1'b0, '0);
            push(32'h60 + 32'(4 * i), 32'h13);
            @(negedge clk);
            checks++;
            if (f.imem_read !== 1'b1 || f.imem_address !== 32'h60 + 32'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr: read=%b addr=%h, required 1 %h",
                         f.imem_read, f.imem_address, 32'h60 + 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (f.valid_out !== 1'b1 || f.pc_out !== 32'h60 + 32'(4 * (i - 1))) begin
                    failures++;
                    $display("FAIL stream_out: valid=%b pc=%h, required 1 %h",
                             f.valid_out, f.pc_out, 32'h60 + 32'(4 * (i - 1)));
                end
            end
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, W0, 1'b0, 1'b0, '0);
        push(32'h60, W0);
        @(negedge clk);
        next_cycle();
        drive(1'b1, W1, 1'b1, 1'b0, '0);
        push(32'h64, W1);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h64) begin
            failures++;
            $display("FAIL stall_req: read=%b addr=%h, required 1 00000064", f.imem_read, f.imem_address);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, (k < 2), 1'b0, '0);
            @(negedge clk);
            checks++;
            if (f.imem_read !== 1'b0 || f.valid_out !== 1'b1 || f.pc_out !== 32'h60) begin
                failures++;
                $display("FAIL stall_hold: read=%b valid=%b pc=%h, required 0 1 00000060",
                         f.imem_read, f.valid_out, f.pc_out);
            end
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.valid_out !== 1'b1 || f.pc_out !== 32'h64 || f.instruction_out !== W1) begin
            failures++;
            $display("FAIL stall_release_out: valid=%b pc=%h ins=%h, required 1 00000064 %h",
                     f.valid_out, f.pc_out, f.instruction_out, W1);
        end
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h68) begin
            failures++;
            $display("FAIL stall_release_req: read=%b addr=%h, required 1 00000068",
                     f.imem_read, f.imem_address);
        end
        next_cycle();
    endtask

    task automatic test_redirect_miss();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W0 + 32'(i), 1'b0, 1'b0, '0);
            push(32'h60 + 32'(4 * i), W0 + 32'(i));
            @(negedge clk);
            next_cycle();
        end
        for (int c = 0; c < 4; c++) begin
            drive((c == 3), BAD, 1'b0, (c == 0), 32'h200);
            @(negedge clk);
            checks++;
            if (f.imem_read !== 1'b1 || f.imem_address !== 32'h70) begin
                failures++;
                $display("FAIL miss_addr_stable: read=%b addr=%h, required 1 00000070",
                         f.imem_read, f.imem_address);
            end
            if (c > 0) begin
                checks++;
                if (f.valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL miss_valid: got %b, required 0", f.valid_out);
                end
            end
            next_cycle();
        end
        drive(1'b1, W2, 1'b0, 1'b0, '0);
        push(32'h200, W2);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h200 || f.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL miss_target: read=%b addr=%h valid=%b, required 1 00000200 0",
                     f.imem_read, f.imem_address, f.valid_out);
        end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_double_redirect();
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h300);
        @(negedge clk);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h400);
        @(negedge clk);
        checks++;
        if (f.imem_address !== 32'h60 || f.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL dbl_discard: addr=%h valid=%b, required 00000060 0", f.imem_address, f.valid_out);
        end
        next_cycle();
        drive(1'b1, BAD, 1'b0, 1'b0, '0);
        @(negedge clk);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h500);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h400) begin
            failures++;
            $display("FAIL dbl_last_wins: read=%b addr=%h, required 1 00000400", f.imem_read, f.imem_address);
        end
        next_cycle();
        drive(1'b1, BAD, 1'b0, 1'b1, 32'h600);
        @(negedge clk);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h600 || f.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL dbl_resp_redirect: read=%b addr=%h valid=%b, required 1 00000600 0",
                     f.imem_read, f.imem_address, f.valid_out);
        end
        next_cycle();
    endtask

    task automatic test_redirect_stall_resp();
        do_reset();
        drive(1'b1, W0, 1'b0, 1'b0, '0);
        push(32'h60, W0);
        @(negedge clk);
        next_cycle();
        drive(1'b1, BAD, 1'b1, 1'b1, 32'h80);
        @(negedge clk);
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.valid_out !== 1'b0 || f.imem_read !== 1'b1 || f.imem_address !== 32'h80) begin
            failures++;
            $display("FAIL rsr_redirect: valid=%b read=%b addr=%h, required 0 1 00000080",
                     f.valid_out, f.imem_read, f.imem_address);
        end
        next_cycle();
        drive(1'b1, W1, 1'b0, 1'b0, '0);
        push(32'h80, W1);
        @(negedge clk);
        next_cycle();
        drive(1'b1, BAD, 1'b1, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.imem_address !== 32'h84) begin
            failures++;
            $display("FAIL rsr_next: addr=%h, required 00000084", f.imem_address);
        end
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b0) begin
            failures++;
            $display("FAIL rsr_hold_read: got %b, required 0", f.imem_read);
        end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.valid_out !== 1'b0 || f.imem_read !== 1'b1 || f.imem_address !== 32'h100) begin
            failures++;
            $display("FAIL rsr_hold_redirect: valid=%b read=%b addr=%h, required 0 1 00000100",
                     f.valid_out, f.imem_read, f.imem_address);
        end
        next_cycle();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        next_cycle();
        drive(1'b1, BAD, 1'b0, 1'b0, '0);
        @(negedge clk);
        next_cycle();
        drive(1'b1, W3, 1'b0, 1'b0, '0);
        push(32'hFFFF_FFFC, W3);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_req: read=%b addr=%h, required 1 fffffffc", f.imem_read, f.imem_address);
        end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: read=%b addr=%h, required 1 00000000", f.imem_read, f.imem_address);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b0) begin
            failures++;
            $display("FAIL midmiss_reset_read: got %b, required 0", f.imem_read);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (f.imem_read !== 1'b1 || f.imem_address !== 32'h60 || f.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL midmiss_restart: read=%b addr=%h valid=%b, required 1 00000060 0",
                     f.imem_read, f.imem_address, f.valid_out);
        end
        next_cycle();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_miss();
        test_double_redirect();
        test_redirect_stall_resp();
        test_wrap_and_reset();
        checks++;
        if (exp_pc_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d instructions never delivered, required 0", exp_pc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
